mips_hazard_ctrl: RTL
=====================

Name: mips_hazard_ctrl

Overview:
- Central hazard and forwarding controller for the 5-stage MIPS32 pipeline.
- Keeps a shadow copy of destination/control info for the EX, MEM and WB stages.
- Drives the EX-stage ALU forward muxes, the MEM-stage store-data mux select `Forward_Mem_to_Mem`, and the ID-stage branch-compare forward selects.
- Sequences load-use and branch-dependency stalls with a small FSM that drives PC/IF-ID write enables and EX bubble insertion.

Parameters:
- `REG_ADDR_W`, 5, register-file address width.
- `FWD_W`, 2, width of the EX forward select codes.

Ports:
- `Clk`  in  1  pipeline clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Rs_ID`  in  5  source reg rs of the instruction in ID.
- `Rt_ID`  in  5  source reg rt of the instruction in ID.
- `Dest_ID`  in  5  write-back destination after the RegDst mux.
- `RegWrite_ID`  in  1  ID instruction writes the register file.
- `MemRead_ID`  in  1  ID instruction is a load.
- `MemWrite_ID`  in  1  ID instruction is a store.
- `Branch_ID`  in  1  ID instruction is beq/bne; compares in ID.
- `Valid_ID`  in  1  ID holds a real instruction.
- `Branch_Taken_ID`  in  1  branch resolved taken this cycle.
- `Forward_A_EX`  out  2  ALU operand A select.
- `Forward_B_EX`  out  2  ALU operand B select.
- `Forward_Mem_to_Mem`  out  1  1 selects `Read_Data_WB` as the store data.
- `Forward_A_ID`  out  1  branch comparator A takes the MEM ALU result.
- `Forward_B_ID`  out  1  branch comparator B takes the MEM ALU result.
- `PC_Write`  out  1  PC update enable.
- `IF_ID_Write`  out  1  IF/ID register enable.
- `ID_EX_Bubble`  out  1  zero the ID/EX control fields.
- `IF_ID_Flush`  out  1  squash the fetched instruction.

Behaviour:
- **Shadow pipeline.** Each stage holds {valid, dest, rt, regwrite, memread, memwrite}. It is loaded from the `*_ID` inputs every rising `Clk`.
  - EX loads a bubble (valid=0) when `ID_EX_Bubble`=1.
  - MEM<=EX and WB<=MEM every cycle.
- **Reset.** On `Reset_n` low, immediately and asynchronously:
  - all shadow valids = 0; FSM = RUN;
  - `PC_Write`=`IF_ID_Write`=1;
  - all other outputs = 0.
- **"Writer" definition.** A stage is a writer if valid && regwrite && dest != 0. Register 0 is never forwarded or stalled on.
- **EX forwarding.** Combinational from the shadow regs, so selects are valid in the same cycle the consumer is in EX.
  - Encoding: 00 register file, 10 MEM ALU result, 01 WB result.
  - If both MEM and WB match, MEM wins.
  - Rs/Rt of the EX consumer are carried in the shadow EX stage.
- **Forward_Mem_to_Mem.** 1 when all of the following hold:
  - MEM is a valid store;
  - WB is a load writer;
  - WB.dest == MEM.rt.
- **ID forwarding.** `Forward_A_ID`/`Forward_B_ID` = 1 when `Branch_ID` and a MEM non-load writer's dest matches Rs_ID/Rt_ID.
- **Stall FSM states: RUN, STALL1, STALL2.**
  - **Load-use**, RUN -> STALL1:
    - EX is a load writer and dest matches Rs_ID (any use), or
    - dest matches Rt_ID and the ID instruction is not a store. A store consumer of a load is covered by MEM-to-MEM forwarding; no stall.
  - **Branch dependencies:**
    - `Branch_ID` dependent on an EX non-load writer -> STALL1.
    - `Branch_ID` dependent on an EX load -> STALL2.
    - `Branch_ID` dependent on a MEM load -> STALL1.
  - **Stall outputs.** In any stall state: `PC_Write`=0, `IF_ID_Write`=0, `ID_EX_Bubble`=1.
  - **Transitions:** STALL2 -> STALL1 -> RUN. The RUN condition is re-evaluated on return.
  - **Stall cycle count.** The stall is asserted combinationally in the detecting cycle, so N stall cycles total = 1 (detect) + FSM cycles.
- **Branch flush.** `IF_ID_Flush` = `Branch_Taken_ID` && not stalling. A branch waiting on data never flushes.
- **Invalid ID.** `Valid_ID`=0 never triggers a stall.

Optional Feature:
- Macro: `MIPS_HAZARD_PERF_EN`.
- With it: 32-bit saturating outputs `Stall_Cycles` and `Fwd_Events`, reset to 0.
  - `Stall_Cycles` counts cycles with `PC_Write`=0.
  - `Fwd_Events` counts cycles with any non-zero forward select.
- Without it: ports and counters are absent.

Decomposition:
- Package `mips_hazard_pkg`:
  - `FWD_RF`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10;
  - FSM state encoding RUN/STALL1/STALL2;
  - stage-record field widths.
- Sub-module `hazard_stage_reg`: one shadow stage record with async reset and a bubble input; instantiated three times.

Test Plan:
- `add $3,$1,$2` then `sub $4,$3,$5` -> in sub's EX: `Forward_A_EX`=10; no stall.
- `lw $3,0($1)` then `add $4,$3,$2` -> one cycle `PC_Write`=0 and `ID_EX_Bubble`=1, then `Forward_A_EX`=01.
- `lw $3,0($1)` then `sw $3,4($2)` -> no stall; `Forward_Mem_to_Mem`=1 when sw in MEM and lw in WB.
- `lw $3,..` then `beq $3,$4` -> two stall cycles; `Branch_Taken_ID`=1 during the stall gives `IF_ID_Flush`=0, then 1 after.
- `add $0,$1,$2` then `sub $4,$0,$5` -> `Forward_A_EX`=00; no stall.
- `Reset_n` low mid-STALL2 -> `PC_Write`=1 and all selects 0 immediately; FSM in RUN after release.

Source files
------------

// File: rtl/mips_hazard_pkg.sv
// rtl/mips_hazard_pkg.sv - shared types and constants for the MIPS hazard/forwarding controller
package mips_hazard_pkg;

    localparam int STG_REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL1 = 2'd1,
        STALL2 = 2'd2
    } stall_state_e;

    typedef struct packed {
        logic                 valid;
        logic [STG_REG_W-1:0] dest;
        logic [STG_REG_W-1:0] rs;
        logic [STG_REG_W-1:0] rt;
        logic                 regwrite;
        logic                 memread;
        logic                 memwrite;
    } stage_t;

    // A stage can only be a forwarding/stall source if it really writes a non-zero register
    function automatic logic is_writer(input stage_t s);
        return s.valid && s.regwrite && (s.dest != '0);
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// rtl/hazard_stage_reg.sv - one shadow pipeline stage record with bubble insertion
module hazard_stage_reg
    import mips_hazard_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   bubble_i,
    input  stage_t d_i,
    output stage_t q_o
);

    stage_t rec_q;
    stage_t rec_d;

    // A bubble clears the whole record so no stale dest/rs/rt can match later
    always_comb begin
        rec_d = d_i;
        if (bubble_i) begin
            rec_d = '0;
        end
    end

    // Record register, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rec_q <= '0;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign q_o = rec_q;

endmodule

// File: rtl/mips_hazard_ctrl.sv
// rtl/mips_hazard_ctrl.sv - hazard/forwarding controller; optional counters under MIPS_HAZARD_PERF_EN
module mips_hazard_ctrl
    import mips_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_W      = 2
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [REG_ADDR_W-1:0] Rs_ID,
    input  logic [REG_ADDR_W-1:0] Rt_ID,
    input  logic [REG_ADDR_W-1:0] Dest_ID,
    input  logic                  RegWrite_ID,
    input  logic                  MemRead_ID,
    input  logic                  MemWrite_ID,
    input  logic                  Branch_ID,
    input  logic                  Valid_ID,
    input  logic                  Branch_Taken_ID,
    output logic [FWD_W-1:0]      Forward_A_EX,
    output logic [FWD_W-1:0]      Forward_B_EX,
    output logic                  Forward_Mem_to_Mem,
    output logic                  Forward_A_ID,
    output logic                  Forward_B_ID,
    output logic                  PC_Write,
    output logic                  IF_ID_Write,
    output logic                  ID_EX_Bubble,
    output logic                  IF_ID_Flush
`ifdef MIPS_HAZARD_PERF_EN
    ,
    output logic [31:0]           Stall_Cycles,
    output logic [31:0]           Fwd_Events
`endif
);

    stage_t id_rec;
    stage_t ex_q;
    stage_t mem_q;
    stage_t wb_q;

    assign id_rec = '{valid:    Valid_ID,
                      dest:     Dest_ID,
                      rs:       Rs_ID,
                      rt:       Rt_ID,
                      regwrite: RegWrite_ID,
                      memread:  MemRead_ID,
                      memwrite: MemWrite_ID};

    hazard_stage_reg u_ex_stage (
        .clk_i    (Clk),
        .rst_ni   (Reset_n),
        .bubble_i (ID_EX_Bubble),
        .d_i      (id_rec),
        .q_o      (ex_q)
    );

    hazard_stage_reg u_mem_stage (
        .clk_i    (Clk),
        .rst_ni   (Reset_n),
        .bubble_i (1'b0),
        .d_i      (ex_q),
        .q_o      (mem_q)
    );

    hazard_stage_reg u_wb_stage (
        .clk_i    (Clk),
        .rst_ni   (Reset_n),
        .bubble_i (1'b0),
        .d_i      (mem_q),
        .q_o      (wb_q)
    );

    logic ex_w, mem_w, wb_w;
    logic ex_load, mem_load;
    logic ex_rs, ex_rt, mem_rs, mem_rt;

    assign ex_w     = is_writer(ex_q);
    assign mem_w    = is_writer(mem_q);
    assign wb_w     = is_writer(wb_q);
    assign ex_load  = ex_w && ex_q.memread;
    assign mem_load = mem_w && mem_q.memread;
    assign ex_rs    = (ex_q.dest == Rs_ID);
    assign ex_rt    = (ex_q.dest == Rt_ID);
    assign mem_rs   = (mem_q.dest == Rs_ID);
    assign mem_rt   = (mem_q.dest == Rt_ID);

    logic [1:0] fwd_a, fwd_b;

    // EX operand selects; MEM is checked first so the youngest producer wins
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (mem_w && (mem_q.dest == ex_q.rs)) begin
            fwd_a = FWD_MEM;
        end else if (wb_w && (wb_q.dest == ex_q.rs)) begin
            fwd_a = FWD_WB;
        end
        if (mem_w && (mem_q.dest == ex_q.rt)) begin
            fwd_b = FWD_MEM;
        end else if (wb_w && (wb_q.dest == ex_q.rt)) begin
            fwd_b = FWD_WB;
        end
    end

    assign Forward_A_EX       = fwd_a;
    assign Forward_B_EX       = fwd_b;
    assign Forward_Mem_to_Mem = mem_q.valid && mem_q.memwrite && wb_w && wb_q.memread
                                && (wb_q.dest == mem_q.rt);
    assign Forward_A_ID       = Branch_ID && mem_w && !mem_q.memread && mem_rs;
    assign Forward_B_ID       = Branch_ID && mem_w && !mem_q.memread && mem_rt;

    logic load_use, br_ex_alu, br_ex_load, br_mem_load;

    // Store data of a load consumer comes via MEM-to-MEM forwarding, so rt alone never stalls a store
    assign load_use    = Valid_ID && ex_load && (ex_rs || (ex_rt && !MemWrite_ID));
    assign br_ex_alu   = Valid_ID && Branch_ID && ex_w && !ex_q.memread && (ex_rs || ex_rt);
    assign br_ex_load  = Valid_ID && Branch_ID && ex_load && (ex_rs || ex_rt);
    assign br_mem_load = Valid_ID && Branch_ID && mem_load && (mem_rs || mem_rt);

    stall_state_e state_q, state_d, detect_state, cur_state;
    logic         stall;

    // The detecting cycle already stalls, so the register only holds the cycles still owed after it
    always_comb begin
        detect_state = RUN;
        if (br_ex_load) begin
            detect_state = STALL2;
        end else if (load_use || br_ex_alu || br_mem_load) begin
            detect_state = STALL1;
        end
        cur_state = (state_q == RUN) ? detect_state : state_q;
        state_d   = (cur_state == STALL2) ? STALL1 : RUN;
        stall     = (cur_state != RUN);
    end

    // Stall FSM state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign PC_Write     = !stall;
    assign IF_ID_Write  = !stall;
    assign ID_EX_Bubble = stall;
    assign IF_ID_Flush  = Reset_n && Branch_Taken_ID && !stall;

    logic unused_fields;
    assign unused_fields = ^{ex_q.memwrite, wb_q.rs, wb_q.rt, wb_q.memwrite, wb_q.valid};

`ifdef MIPS_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, fwd_cnt_q;
    logic        any_fwd;

    assign any_fwd = (fwd_a != FWD_RF) || (fwd_b != FWD_RF) || Forward_Mem_to_Mem
                     || Forward_A_ID || Forward_B_ID;

    // Saturating event counters
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (!PC_Write && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (any_fwd && (fwd_cnt_q != '1)) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
        end
    end

    assign Stall_Cycles = stall_cnt_q;
    assign Fwd_Events   = fwd_cnt_q;
`endif

endmodule
